// File: rtl/reg_arb_pkg.sv
// Shared types and helper functions for the round-robin register write arbiter.
// Functions work on maximum-width vectors; callers size-cast at the boundary.
package reg_arb_pkg;

    localparam int MAX_REQ    = 16;
    localparam int MAX_IDX_W  = 4;
    localparam int MAX_REGS   = 64;
    localparam int MAX_ADDR_W = 6;

    typedef struct packed {
        logic                 found;
        logic [MAX_IDX_W-1:0] idx;
    } pick_t;

    // First set bit of valid at or after ptr, searching upward modulo n.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                      input logic [MAX_IDX_W-1:0] ptr,
                                      input int n);
        pick_t res;
        int    cand;
        res.found = 1'b0;
        res.idx   = {MAX_IDX_W{1'b0}};
        for (int k = 0; k < MAX_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= n) begin
                cand = cand - n;
            end
            if (k < n) begin
                if (!res.found && valid[cand]) begin
                    res.found = 1'b1;
                    res.idx   = cand[MAX_IDX_W-1:0];
                end
            end
        end
        return res;
    endfunction

    function automatic logic [MAX_REGS-1:0] onehot_decode(input logic [MAX_ADDR_W-1:0] addr,
                                                          input int n);
        logic [MAX_REGS-1:0] res;
        res = {MAX_REGS{1'b0}};
        if (int'(addr) < n) begin
            res[addr] = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational rotating-priority search: winner is the first valid index at or
// after rr_ptr. Holds no state.
module rr_priority_picker
    import reg_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [PTR_W-1:0]   winner,
    output logic               any
);

    pick_t pick_s;

    // Widen to the helper's fixed width, then narrow the result back
    always_comb begin
        pick_s = rr_pick(MAX_REQ'(valid), MAX_IDX_W'(rr_ptr), NUM_REQ);
        winner = PTR_W'(pick_s.idx);
        any    = pick_s.found;
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter multiplexing NUM_REQ requesters onto one registered
// write path (one-hot enables plus shared data) into a register bank.
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int NUM_REGS   = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           arb_en,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*$clog2(NUM_REGS)-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REGS-1:0]            reg_we,
    output logic [DATA_WIDTH-1:0]          reg_wdata,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id,
    output logic                           err_oor
);

    localparam int ADDR_W = $clog2(NUM_REGS);
    localparam int PTR_W  = $clog2(NUM_REQ);

    logic [PTR_W-1:0]      rr_ptr_r;
    logic [NUM_REGS-1:0]   reg_we_r;
    logic [DATA_WIDTH-1:0] reg_wdata_r;
    logic [PTR_W-1:0]      grant_id_r;
    logic                  err_oor_r;

    logic [PTR_W-1:0]      winner_s;
    logic                  any_s;
    logic [NUM_REQ-1:0]    req_ready_s;
    logic                  xfer_s;
    logic [ADDR_W-1:0]     addr_sel_s;
    logic [DATA_WIDTH-1:0] data_sel_s;
    logic [NUM_REGS-1:0]   we_next_s;
    logic                  oor_s;
    logic [PTR_W-1:0]      ptr_next_s;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .valid  (req_valid),
        .rr_ptr (rr_ptr_r),
        .winner (winner_s),
        .any    (any_s)
    );

    // Grant vector; never looks at address or data, and is silenced in reset
    always_comb begin
        req_ready_s = {NUM_REQ{1'b0}};
        if (rst && arb_en && any_s) begin
            req_ready_s[winner_s] = 1'b1;
        end else begin
            req_ready_s = {NUM_REQ{1'b0}};
        end
    end

    // Winner's payload, decoded enable and the pointer advance
    always_comb begin
        xfer_s     = |req_ready_s;
        addr_sel_s = req_addr[int'(winner_s)*ADDR_W +: ADDR_W];
        data_sel_s = req_data[int'(winner_s)*DATA_WIDTH +: DATA_WIDTH];
        we_next_s  = NUM_REGS'(onehot_decode(MAX_ADDR_W'(addr_sel_s), NUM_REGS));
        oor_s      = (int'(addr_sel_s) >= NUM_REGS);
        if (winner_s == PTR_W'(NUM_REQ - 1)) begin
            ptr_next_s = {PTR_W{1'b0}};
        end else begin
            ptr_next_s = winner_s + PTR_W'(1);
        end
    end

    // Write-path registers; enables and error are single-cycle strobes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_r    <= {PTR_W{1'b0}};
            reg_we_r    <= {NUM_REGS{1'b0}};
            reg_wdata_r <= {DATA_WIDTH{1'b0}};
            grant_id_r  <= {PTR_W{1'b0}};
            err_oor_r   <= 1'b0;
        end else if (xfer_s) begin
            rr_ptr_r    <= ptr_next_s;
            reg_we_r    <= we_next_s;
            reg_wdata_r <= data_sel_s;
            grant_id_r  <= winner_s;
            err_oor_r   <= oor_s;
        end else begin
            reg_we_r    <= {NUM_REGS{1'b0}};
            err_oor_r   <= 1'b0;
        end
    end

    assign req_ready = req_ready_s;
    assign reg_we    = reg_we_r;
    assign reg_wdata = reg_wdata_r;
    assign grant_id  = grant_id_r;
    assign err_oor   = err_oor_r;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed scoreboard bench: an 8-register and a 6-register arbiter share stimulus.
module tb_reg_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        arb_en;
    logic [3:0]  req_valid;
    logic [11:0] req_addr;
    logic [31:0] req_data;

    logic [3:0]  req_ready8, req_ready6;
    logic [7:0]  reg_we8;
    logic [5:0]  reg_we6;
    logic [7:0]  reg_wdata8, reg_wdata6;
    logic [1:0]  grant_id8, grant_id6;
    logic        err_oor8, err_oor6;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] we8;
        logic [5:0] we6;
        logic       oor6;
        logic [7:0] wdata;
        logic [1:0] gid;
    } exp_t;

    exp_t q[$];

    int         m_ptr   = 0;
    logic [7:0] m_wdata = 8'h00;
    logic [1:0] m_gid   = 2'd0;

    reg_write_arbiter #(.NUM_REQ(4), .NUM_REGS(8), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .arb_en(arb_en), .req_valid(req_valid),
        .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready8),
        .reg_we(reg_we8), .reg_wdata(reg_wdata8), .grant_id(grant_id8), .err_oor(err_oor8)
    );

    reg_write_arbiter #(.NUM_REQ(4), .NUM_REGS(6), .DATA_WIDTH(8)) dut6 (
        .clk(clk), .rst(rst), .arb_en(arb_en), .req_valid(req_valid),
        .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready6),
        .reg_we(reg_we6), .reg_wdata(reg_wdata6), .grant_id(grant_id6), .err_oor(err_oor6)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Drive one cycle of requests, check the grant, then check the registered result.
    task automatic step(input logic en, input logic [3:0] v,
                        input logic [11:0] a, input logic [31:0] d);
        logic [3:0] exp_ready;
        logic [7:0] one8;
        logic [5:0] one6;
        logic [2:0] ad;
        int         w;
        exp_t       e, got;
        arb_en = en; req_valid = v; req_addr = a; req_data = d;
        #1;
        exp_ready = 4'b0000;
        w = -1;
        if (en) begin
            for (int k = 0; k < 4; k++) begin
                if (w < 0 && v[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
            end
        end
        if (w >= 0) exp_ready[w] = 1'b1;
        chk("req_ready", 32'(req_ready8), 32'(exp_ready));
        chk("req_ready6", 32'(req_ready6), 32'(exp_ready));
        one8 = 8'd1;
        one6 = 6'd1;
        if (w >= 0) begin
            ad      = a[w*3 +: 3];
            e.we8   = one8 << ad;
            e.we6   = (ad < 3'd6) ? (one6 << ad) : 6'd0;
            e.oor6  = (ad >= 3'd6);
            m_wdata = d[w*8 +: 8];
            m_gid   = 2'(w);
            m_ptr   = (w + 1) % 4;
        end else begin
            e.we8  = 8'h00;
            e.we6  = 6'h00;
            e.oor6 = 1'b0;
        end
        e.wdata = m_wdata;
        e.gid   = m_gid;
        q.push_back(e);
        @(posedge clk);
        #1;
        got = q.pop_front();
        chk("reg_we", 32'(reg_we8), 32'(got.we8));
        chk("reg_we6", 32'(reg_we6), 32'(got.we6));
        chk("err_oor", 32'(err_oor8), 32'd0);
        chk("err_oor6", 32'(err_oor6), 32'(got.oor6));
        chk("reg_wdata", 32'(reg_wdata8), 32'(got.wdata));
        chk("reg_wdata6", 32'(reg_wdata6), 32'(got.wdata));
        chk("grant_id", 32'(grant_id8), 32'(got.gid));
        chk("grant_id6", 32'(grant_id6), 32'(got.gid));
    endtask

    initial begin
        rst = 1'b1; arb_en = 1'b1; req_valid = 4'b1111;
        req_addr = 12'h000; req_data = 32'h0;
        #2 rst = 1'b0;
        #1;
        chk("rst_ready", 32'(req_ready8), 32'd0);
        chk("rst_we", 32'(reg_we8), 32'd0);
        chk("rst_wdata", 32'(reg_wdata8), 32'd0);
        chk("rst_gid", 32'(grant_id8), 32'd0);
        chk("rst_oor", 32'(err_oor6), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Single request from requester 2 to register 5
        step(1'b1, 4'b0100, {3'd0, 3'd5, 3'd0, 3'd0}, {8'h00, 8'hA5, 8'h00, 8'h00});
        // Pointer now 3: requester 3 then 1, then all-valid proves pointer is 2
        step(1'b1, 4'b1010, {3'd4, 3'd0, 3'd3, 3'd0}, {8'h44, 8'h00, 8'h11, 8'h00});
        step(1'b1, 4'b0010, {3'd4, 3'd0, 3'd3, 3'd0}, {8'h44, 8'h00, 8'h11, 8'h00});
        step(1'b1, 4'b1111, {3'd7, 3'd6, 3'd1, 3'd0}, {8'h78, 8'h56, 8'h34, 8'h12});
        // All four continuously requesting: back-to-back rotating grants
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 4'b1111, {3'(i), 3'(i + 1), 3'(i + 2), 3'(i + 3)}, $urandom);
        end
        // Out-of-range for the 6-register bank
        step(1'b1, 4'b0010, {3'd0, 3'd0, 3'd7, 3'd0}, {8'h00, 8'h00, 8'h3C, 8'h00});
        step(1'b1, 4'b0000, 12'h000, 32'h0);
        // Transfer, then arb_en low for three cycles, then re-enabled
        step(1'b1, 4'b0001, {3'd0, 3'd0, 3'd0, 3'd2}, {8'h00, 8'h00, 8'h00, 8'h5A});
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'b0001, {3'd0, 3'd0, 3'd0, 3'd6}, {8'h00, 8'h00, 8'h00, 8'hC3});
        end
        step(1'b1, 4'b0001, {3'd0, 3'd0, 3'd0, 3'd6}, {8'h00, 8'h00, 8'h00, 8'hC3});
        // Transfer to register 1, then asynchronous reset mid-cycle
        step(1'b1, 4'b0100, {3'd0, 3'd1, 3'd0, 3'd0}, {8'h00, 8'h99, 8'h00, 8'h00});
        arb_en = 1'b1; req_valid = 4'b1111;
        rst = 1'b0;
        #1;
        chk("async_we", 32'(reg_we8), 32'd0);
        chk("async_gid", 32'(grant_id8), 32'd0);
        chk("async_wdata", 32'(reg_wdata8), 32'd0);
        chk("async_ready", 32'(req_ready8), 32'd0);
        m_ptr = 0; m_wdata = 8'h00; m_gid = 2'd0;
        @(posedge clk); #1;
        chk("hold_we", 32'(reg_we8), 32'd0);
        rst = 1'b1;
        step(1'b1, 4'b0000, 12'h000, 32'h0);
        step(1'b1, 4'b1111, {3'd3, 3'd2, 3'd1, 3'd4}, {8'hDD, 8'hCC, 8'hBB, 8'hAA});
        chk("queue_empty", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
